// File: rtl/crg_io_bridge.sv
// crg_io_bridge: deserialises config records, times the run pulse, buffers and serialises result records.
// Define CRG_IO_PARITY_EN to reject config loads containing any beat with bad even parity.
module crg_io_bridge #(
    parameter int BUS_W     = 112,
    parameter int CFG_BEATS = 2,
    parameter int OUT_BEATS = 7,
    parameter int DEPTH     = 2,
    parameter int RUN_LEN   = 7
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [BUS_W-1:0]           bus_in_i,
    input  logic                       bus_in_vld_i,
    input  logic                       bus_in_par_i,
    output logic [CFG_BEATS*BUS_W-1:0] cfg_o,
    output logic                       cfg_vld_o,
    output logic                       run_o,
    output logic                       err_o,
    input  logic [OUT_BEATS*BUS_W-1:0] res_i,
    input  logic                       res_vld_i,
    output logic                       res_rdy_o,
    output logic [BUS_W-1:0]           bus_out_o,
    output logic                       bus_out_oe_o,
    input  logic                       bus_out_rdy_i
);
    localparam int SW = CFG_BEATS * BUS_W;
    localparam int CW = $clog2(CFG_BEATS + 2);
    localparam int BW = OUT_BEATS > 1 ? $clog2(OUT_BEATS) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int FW = PW + 1;
    localparam int RW = $clog2(RUN_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CFG_BEATS + 1);
    localparam logic [CW-1:0] CNT_OK   = CW'(CFG_BEATS);
    localparam logic [BW-1:0] LAST     = BW'(OUT_BEATS - 1);
    localparam logic [FW-1:0] FULL     = FW'(DEPTH);
    localparam logic [RW-1:0] RUN_INIT = RW'(RUN_LEN);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         stg_q, stg_d, cfg_q, cfg_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  bad_q, bad_d, cfg_vld_q, cfg_vld_d, err_q, err_d;
    logic [RW-1:0]         run_q, run_d;
    logic                  done, commit, par_err;

    logic [OUT_BEATS-1:0][BUS_W-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [FW-1:0]         fcnt_q, fcnt_d;
    logic                  rdy_q, rdy_d;
    logic [BW-1:0]         beat_q, beat_d, sel;
    logic                  push, pop, adv;

`ifdef CRG_IO_PARITY_EN
    assign par_err = bus_in_vld_i && (bus_in_par_i != ^bus_in_i);
`else
    logic unused_par;
    assign unused_par = bus_in_par_i;
    assign par_err    = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            stg_q     <= '0;
            cnt_q     <= '0;
            bad_q     <= 1'b0;
            cfg_q     <= '0;
            cfg_vld_q <= 1'b0;
            err_q     <= 1'b0;
            run_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            fcnt_q    <= '0;
            rdy_q     <= 1'b1;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            stg_q     <= stg_d;
            cnt_q     <= cnt_d;
            bad_q     <= bad_d;
            cfg_q     <= cfg_d;
            cfg_vld_q <= cfg_vld_d;
            err_q     <= err_d;
            run_q     <= run_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            fcnt_q    <= fcnt_d;
            rdy_q     <= rdy_d;
            beat_q    <= beat_d;
        end
    end

    // Every valid cycle is a beat; the first low cycle ends the load.
    always_comb state_d = bus_in_vld_i ? LOAD : IDLE;

    always_comb begin
        done      = state_q == LOAD && !bus_in_vld_i;
        commit    = done && cnt_q == CNT_OK && !bad_q;
        stg_d     = bus_in_vld_i ? (stg_q << BUS_W) | SW'(bus_in_i) : stg_q;
        cnt_d     = !bus_in_vld_i ? cnt_q : state_q == IDLE ? CW'(1) : cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1;
        bad_d     = bus_in_vld_i ? (state_q == LOAD && bad_q) || par_err : bad_q;
        cfg_d     = commit ? stg_q : cfg_q;
        cfg_vld_d = commit;
        err_d     = commit ? 1'b0 : done ? 1'b1 : err_q;
        run_d     = commit ? RUN_INIT : run_q != '0 ? run_q - 1'b1 : run_q;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_q] <= res_i;
    end

    // The host owns the bus whenever it drives; the serialiser just stalls on its current beat.
    assign bus_out_oe_o = fcnt_q != '0 && !bus_in_vld_i;
    assign adv          = bus_out_oe_o && bus_out_rdy_i;
    assign pop          = adv && beat_q == LAST;
    assign push         = res_vld_i && rdy_q;

    always_comb begin
        wr_d   = push ? wr_q + 1'b1 : wr_q;
        rd_d   = pop ? rd_q + 1'b1 : rd_q;
        fcnt_d = fcnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        rdy_d  = fcnt_d != FULL;
        beat_d = !adv ? beat_q : pop ? '0 : beat_q + 1'b1;
        sel    = LAST - beat_q;
    end

    assign bus_out_o = fcnt_q == '0 ? '0 : mem[rd_q][sel];
    assign cfg_o     = cfg_q;
    assign cfg_vld_o = cfg_vld_q;
    assign err_o     = err_q;
    assign run_o     = run_q != '0;
    assign res_rdy_o = rdy_q;
endmodule

// File: tb/tb_crg_io_bridge.sv
// tb_crg_io_bridge: randomized scoreboard bench for crg_io_bridge (honours CRG_IO_PARITY_EN if defined).
module tb_crg_io_bridge;
    localparam int BUS_W = 112, CFG_BEATS = 2, OUT_BEATS = 7, DEPTH = 2, RUN_LEN = 7;
    localparam int CFG_W = CFG_BEATS * BUS_W, REC_W = OUT_BEATS * BUS_W;
`ifdef CRG_IO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic             clk = 0, rst_n_i = 0;
    logic [BUS_W-1:0] bus_in_i = '0;
    logic             bus_in_vld_i = 0, bus_in_par_i = 0;
    logic [CFG_W-1:0] cfg_o;
    logic             cfg_vld_o, run_o, err_o;
    logic [REC_W-1:0] res_i = '0;
    logic             res_vld_i = 0, res_rdy_o;
    logic [BUS_W-1:0] bus_out_o;
    logic             bus_out_oe_o, bus_out_rdy_i = 0;

    crg_io_bridge #(.BUS_W(BUS_W), .CFG_BEATS(CFG_BEATS), .OUT_BEATS(OUT_BEATS), .DEPTH(DEPTH), .RUN_LEN(RUN_LEN)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .bus_in_i(bus_in_i), .bus_in_vld_i(bus_in_vld_i), .bus_in_par_i(bus_in_par_i),
        .cfg_o(cfg_o), .cfg_vld_o(cfg_vld_o), .run_o(run_o), .err_o(err_o),
        .res_i(res_i), .res_vld_i(res_vld_i), .res_rdy_o(res_rdy_o),
        .bus_out_o(bus_out_o), .bus_out_oe_o(bus_out_oe_o), .bus_out_rdy_i(bus_out_rdy_i)
    );

    always #5 clk = ~clk;

    typedef struct {bit good; logic [CFG_W-1:0] cfg;} out_t;

    int               n_chk = 0, n_fail = 0;
    logic [BUS_W-1:0] beat_q[$];
    out_t             outq[$];
    out_t             mo;
    logic [CFG_W-1:0] model_cfg = '0, exp_cfg = '0;
    bit               exp_err = 0, pend = 0, prev_vld = 0;
    int               run_rem = 0, recs;
    bit               exp_oe;

    task automatic chk(input string name, input logic [CFG_W-1:0] act, input logic [CFG_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BUS_W-1:0] rbeat();
        logic [BUS_W-1:0] b = '0;
        for (int i = 0; i < (BUS_W + 31) / 32; i++) b = (b << 32) | BUS_W'($urandom());
        return b;
    endfunction

    function automatic logic [REC_W-1:0] rrec();
        logic [REC_W-1:0] r = '0;
        for (int i = 0; i < OUT_BEATS; i++) r = (r << BUS_W) | REC_W'(rbeat());
        return r;
    endfunction

    // A load is good only with exactly CFG_BEATS beats and (when checked) clean parity.
    task automatic do_load(input int n, input int bad_beat, input bit fixed);
        logic [CFG_W-1:0] acc = '0;
        logic [BUS_W-1:0] b;
        bit bad = 0;
        out_t o;
        for (int i = 0; i < n; i++) begin
            b = fixed ? (i == 0 ? {(BUS_W/4){4'hA}} : {(BUS_W/4){4'h5}}) : rbeat();
            @(posedge clk); #1;
            bus_in_i = b;
            bus_in_vld_i = 1;
            bus_in_par_i = (^b) ^ (i == bad_beat);
            acc = (acc << BUS_W) | CFG_W'(b);
            if (i == bad_beat) bad = 1;
        end
        @(posedge clk); #1;
        bus_in_vld_i = 0;
        bus_in_i = '0;
        bus_in_par_i = 0;
        o.good = n == CFG_BEATS && !(PAR_EN && bad);
        if (o.good) model_cfg = acc;
        o.cfg = model_cfg;
        outq.push_back(o);
    endtask

    task automatic push_recs(input int n);
        for (int k = 0; k < n; k++) begin
            bit acc;
            acc = 0;
            res_i = rrec();
            res_vld_i = 1;
            for (int t = 0; t < 100 && !acc; t++) begin
                @(negedge clk);
                acc = res_rdy_o;
                @(posedge clk); #1;
            end
            if (!acc) begin
                n_chk++; n_fail++;
                $display("FAIL push_timeout: res_rdy_o stayed 0, required 1 within 100 cycles");
            end
        end
        res_vld_i = 0;
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && beat_q.size() != 0; t++) begin @(posedge clk); #1; end
        if (beat_q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: %0d beats still pending, required 0", beat_q.size());
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_cfg", cfg_o, '0);
        chk("rst_cfg_vld", cfg_vld_o, 0);
        chk("rst_run", run_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_res_rdy", res_rdy_o, 1);
        chk("rst_bus_out", bus_out_o, '0);
        chk("rst_oe", bus_out_oe_o, 0);
    endtask

    task automatic clear_model();
        beat_q.delete(); outq.delete();
        model_cfg = '0; exp_cfg = '0; exp_err = 0;
        run_rem = 0; pend = 0; prev_vld = 0;
    endtask

    // Monitor: output bus against the queued beat stream, loader against queued load outcomes.
    always @(negedge clk) if (rst_n_i) begin
        recs = (beat_q.size() + OUT_BEATS - 1) / OUT_BEATS;
        exp_oe = beat_q.size() != 0 && !bus_in_vld_i;
        chk("res_rdy", res_rdy_o, recs != DEPTH);
        chk("oe", bus_out_oe_o, exp_oe);
        if (beat_q.size() == 0) chk("bus_out_empty", bus_out_o, '0);
        else begin
            chk("bus_out", bus_out_o, beat_q[0]);
            if (exp_oe && bus_out_rdy_i) void'(beat_q.pop_front());
        end
        if (res_vld_i && recs != DEPTH)
            for (int k = OUT_BEATS - 1; k >= 0; k--) beat_q.push_back(res_i[k*BUS_W +: BUS_W]);
        if (pend) begin
            if (outq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL load_outcome: load ended with no expected outcome queued");
            end else begin
                mo = outq.pop_front();
                chk("cfg_vld", cfg_vld_o, mo.good);
                if (mo.good) begin
                    exp_cfg = mo.cfg;
                    run_rem = RUN_LEN;
                end
                exp_err = !mo.good;
            end
        end else chk("cfg_vld_idle", cfg_vld_o, 0);
        chk("cfg", cfg_o, exp_cfg);
        chk("err", err_o, exp_err);
        chk("run", run_o, run_rem != 0);
        if (run_rem != 0) run_rem--;
        pend = prev_vld && !bus_in_vld_i;
        prev_vld = bus_in_vld_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #2;
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n_i = 1;
        bus_out_rdy_i = 1;
        do_load(2, -1, 1);
        do_load(3, -1, 0);
        repeat (3) @(posedge clk);
        do_load(2, -1, 0);
        do_load(1, -1, 0);
        do_load(2, 1, 0);
        repeat (8) @(posedge clk);
        @(posedge clk); #1;
        push_recs(3);
        drain();
        @(posedge clk); #1;
        res_i = rrec();
        res_vld_i = 1;
        @(posedge clk); #1;
        res_vld_i = 0;
        repeat (2) @(posedge clk);
        do_load(4, -1, 0);
        drain();
        fork
            for (int k = 0; k < 150; k++) begin
                do_load($urandom_range(1, 4), ($urandom % 5 == 0) ? $urandom_range(0, 3) : -1, 0);
                repeat ($urandom_range(0, 5)) @(posedge clk);
            end
            for (int c = 0; c < 3000; c++) begin
                @(posedge clk); #1;
                res_vld_i = $urandom % 3 == 0;
                res_i = rrec();
                bus_out_rdy_i = $urandom % 4 != 0;
            end
        join
        res_vld_i = 0;
        bus_out_rdy_i = 1;
        drain();
        repeat (10) @(posedge clk);
        #1;
        do_load(2, -1, 0);
        push_recs(2);
        repeat (2) @(posedge clk);
        #2;
        rst_n_i = 0;
        #1;
        check_reset_outputs();
        clear_model();
        @(posedge clk); #1;
        chk("rst_hold_oe", bus_out_oe_o, 0);
        rst_n_i = 1;
        do_load(2, -1, 0);
        push_recs(1);
        drain();
        repeat (10) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
